// File: rtl/tlv_encoder.sv
// tlv_encoder
// -----------------------------------------------------------------------------
// CPU-programmed TLV frame generator. Software loads TYPE and LENGTH, pushes
// LENGTH value words into a small FIFO, then writes CTRL bit0 to start. The
// encoder emits a header word {TYPE, LENGTH, 32'd0} tagged 0xFF, followed by
// the value words popped from the FIFO (last one tagged 0x80, others 0x00),
// and finally increments the frame counter TXCNT.
//
// Optional feature (macro TLV_ENC_CHECKSUM_EN): after the last value word a
// trailer word equal to the XOR of the header and all value words is emitted
// with tag 0x80; value words are then all tagged 0x00. Frames with LENGTH=0
// carry no trailer. With the macro undefined no checksum logic exists.
//
// Register map (cpu_ain[2:0]; upper address bits ignored):
//   0 CTRL   write bit0=1 starts a frame (reads 0)
//   1 TYPE   [15:0]
//   2 LENGTH [15:0], number of value words
//   3 VALUE  write pushes one word into the FIFO (reads 0)
//   4 STATUS {48'd0, busy, err, ovf, full, empty, 7'd0, count[3:0]}
//   5 TXCNT  {32'd0, frames sent}
//   7 CLEAR  any write clears err and ovf
//   6        reads 0, writes ignored
//
// Ports:
//   clk, rst   single rising-edge clock, synchronous active-high reset
//   cpu_din    CPU write data
//   cpu_ain    CPU register address
//   cpu_wren   CPU write strobe (one write per high cycle)
//   cpu_dout   registered read data for the address presented last cycle
//   out_data   transmitted word
//   out_ctrl   tag of the transmitted word
//   out_wr     transmitted word valid strobe (registered)
//   out_rdy    downstream can accept a word this cycle
//   dbg_state  current FSM state (0 IDLE, 1 HDR, 2 VAL, 3 DONE, 4 TRL)
//
// Output handshake: the encoder only commits a word in a cycle where out_rdy
// is 1; that word appears on out_data/out_ctrl with out_wr=1 for exactly one
// cycle after the edge. When out_rdy is 0 the FSM holds its state and nothing
// is popped, so no word is lost or repeated.
//
// DEPTH must be a power of two and at least 2; the STATUS count field is 4
// bits wide.
// -----------------------------------------------------------------------------
module tlv_encoder #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           cpu_din,
    input  logic [63:0]           cpu_ain,
    input  logic                  cpu_wren,
    output logic [63:0]           cpu_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [2:0]            dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_VAL  = 3'd2,
        S_DONE = 3'd3
`ifdef TLV_ENC_CHECKSUM_EN
        ,
        S_TRL  = 3'd4
`endif
    } state_t;

    state_t state;

    // Register file
    logic [15:0] type_reg;
    logic [15:0] len_reg;
    logic [31:0] txcnt;
    logic        err;
    logic        ovf;
    logic [15:0] remaining;

    // Value FIFO
    logic [DATA_WIDTH-1:0] buf_mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;

`ifdef TLV_ENC_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;
`endif

    // Address decode
    logic [2:0] addr;
    logic       wr_ctrl;
    logic       wr_type;
    logic       wr_len;
    logic       wr_value;
    logic       wr_clear;
    logic       start_req;
    logic       start_ok;
    logic       pop;
    logic       push_ok;
    logic       busy;
    logic [63:0] hdr64;
    logic [63:0] status;
    logic        unused_ain;

    assign addr       = cpu_ain[2:0];
    assign unused_ain = ^cpu_ain[63:3];

    always_comb begin
        wr_ctrl  = 1'b0;
        wr_type  = 1'b0;
        wr_len   = 1'b0;
        wr_value = 1'b0;
        wr_clear = 1'b0;
        if (cpu_wren) begin
            case (addr)
                3'd0:    wr_ctrl  = 1'b1;
                3'd1:    wr_type  = 1'b1;
                3'd2:    wr_len   = 1'b1;
                3'd3:    wr_value = 1'b1;
                3'd7:    wr_clear = 1'b1;
                default: ;
            endcase
        end
    end

    assign start_req = wr_ctrl && cpu_din[0];
    // A frame may only start when it fits in the FIFO and is fully loaded.
    assign start_ok  = (32'(len_reg) <= 32'(DEPTH)) && (32'(count) >= 32'(len_reg));

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != S_IDLE);

    // Pops happen only for accepted value words. A push into a full FIFO
    // still succeeds when a pop frees a slot in the same cycle.
    assign pop     = (state == S_VAL) && out_rdy;
    assign push_ok = wr_value && (!full || pop);

    assign hdr64  = {type_reg, len_reg, 32'd0};
    assign status = {48'd0, busy, err, ovf, full, empty, 7'd0, 4'(count)};

    assign dbg_state = state;

    // FIFO storage (no reset needed; validity is tracked by count)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            buf_mem[wr_ptr] <= DATA_WIDTH'(cpu_din);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Frame FSM, registers and output word
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            type_reg  <= '0;
            len_reg   <= '0;
            txcnt     <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            remaining <= '0;
            out_wr    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
`ifdef TLV_ENC_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            out_wr <= 1'b0;

            if (wr_clear) begin
                err <= 1'b0;
                ovf <= 1'b0;
            end
            // Dropped push; placed after the clear so a same-cycle event wins.
            if (wr_value && full && !pop) begin
                ovf <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (wr_type) type_reg <= cpu_din[15:0];
                    if (wr_len)  len_reg  <= cpu_din[15:0];
                    if (start_req) begin
                        if (start_ok) begin
                            state <= S_HDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_HDR: begin
                    if (out_rdy) begin
                        out_wr    <= 1'b1;
                        out_data  <= DATA_WIDTH'(hdr64);
                        out_ctrl  <= CTRL_WIDTH'(8'hFF);
                        remaining <= len_reg;
`ifdef TLV_ENC_CHECKSUM_EN
                        csum      <= DATA_WIDTH'(hdr64);
`endif
                        state     <= (len_reg != 16'd0) ? S_VAL : S_DONE;
                    end
                end

                S_VAL: begin
                    if (out_rdy) begin
                        out_wr    <= 1'b1;
                        out_data  <= buf_mem[rd_ptr];
                        remaining <= remaining - 16'd1;
`ifdef TLV_ENC_CHECKSUM_EN
                        out_ctrl  <= CTRL_WIDTH'(8'h00);
                        csum      <= csum ^ buf_mem[rd_ptr];
                        if (remaining == 16'd1) state <= S_TRL;
`else
                        out_ctrl  <= (remaining == 16'd1) ? CTRL_WIDTH'(8'h80)
                                                          : CTRL_WIDTH'(8'h00);
                        if (remaining == 16'd1) state <= S_DONE;
`endif
                    end
                end

`ifdef TLV_ENC_CHECKSUM_EN
                S_TRL: begin
                    if (out_rdy) begin
                        out_wr   <= 1'b1;
                        out_data <= csum;
                        out_ctrl <= CTRL_WIDTH'(8'h80);
                        state    <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    txcnt <= txcnt + 32'd1;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered CPU read port
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_dout <= '0;
        end else begin
            case (addr)
                3'd1:    cpu_dout <= {48'd0, type_reg};
                3'd2:    cpu_dout <= {48'd0, len_reg};
                3'd4:    cpu_dout <= status;
                3'd5:    cpu_dout <= {32'd0, txcnt};
                default: cpu_dout <= '0;
            endcase
        end
    end

endmodule

// File: doc/tlv_encoder.md
TLV_ENCODER -- requirements
Module: tlv_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, output data word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default 8, output control width.
REQ-003 SHALL have parameter DEPTH, default 8, value buffer entries (power of 2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 cpu_din  input  64  CPU write data.
REQ-007 cpu_ain  input  64  CPU register address; only bits [2:0] decoded.
REQ-008 cpu_wren  input  1  CPU write strobe, one write per cycle high.
REQ-009 cpu_dout  output  64  CPU read data for cpu_ain.
REQ-010 out_data  output  DATA_WIDTH  transmitted word.
REQ-011 out_ctrl  output  CTRL_WIDTH  word control tag.
REQ-012 out_wr  output  1  word valid strobe.
REQ-013 out_rdy  input  1  downstream can accept a word this cycle.

Function
REQ-014 Register map: 0 CTRL (write bit0=1 starts), 1 TYPE [15:0], 2 LENGTH [15:0] in value words, 3 VALUE (write pushes buffer), 4 STATUS (read only), 5 TXCNT (read only), 7 CLEAR (any write clears sticky bits); other addresses read 0, ignore writes.
REQ-015 STATUS SHALL read {48'd0, busy[15], err[14], ovf[13], full[12], empty[11], 7'd0, count[3:0]}.
REQ-016 cpu_dout SHALL be registered: value for cpu_ain in cycle N appears in cycle N+1.
REQ-017 VALUE write when full SHALL drop the data and set ovf; write with pop in same cycle SHALL succeed when full.
REQ-018 FSM states IDLE, HDR, VAL, DONE.
REQ-019 IDLE -> HDR on start only if LENGTH <= DEPTH and count >= LENGTH; otherwise set err, remain IDLE.
REQ-020 Start while busy SHALL be ignored without setting err; TYPE/LENGTH writes while busy SHALL be ignored.
REQ-021 HDR: when out_rdy=1, emit out_data={TYPE, LENGTH, 32'd0}, out_ctrl=8'hFF; -> VAL if LENGTH>0, else DONE.
REQ-022 VAL: when out_rdy=1, pop buffer head to out_data; out_ctrl=8'h80 on last value word, else 8'h00; -> DONE after LENGTH words.
REQ-023 DONE: increment TXCNT (32-bit, wraps at 2^32-1 to 0), -> IDLE next cycle.
REQ-024 out_wr SHALL be registered, high exactly one cycle per word, and never asserted for a word in a cycle where out_rdy was 0; out_rdy low stalls state with no word lost or duplicated.
REQ-025 busy SHALL be 1 in HDR, VAL, DONE; start-to-first-out_wr latency 2 cycles with out_rdy held high.
REQ-026 Buffer pointers SHALL wrap modulo DEPTH; count SHALL track pushes minus pops exactly.

Reset
REQ-027 rst=1 SHALL force IDLE, empty buffer, TYPE=LENGTH=0, TXCNT=0, err=ovf=0, out_wr=0, out_data=0, out_ctrl=0, cpu_dout=0 on next edge.
REQ-028 rst mid-frame SHALL abort without emitting further words; no partial trailer.

Configuration
REQ-029 Macro TLV_ENC_CHECKSUM_EN defined: after last value word, emit one trailer word = XOR of header and all value words, out_ctrl=8'h80 on trailer, last value word tagged 8'h00; LENGTH field unchanged.
REQ-030 Macro TLV_ENC_CHECKSUM_EN undefined: no trailer, behaviour per REQ-022; no checksum logic.

Verification
REQ-031 TYPE=0x0005, LENGTH=2, push 0xA, 0xB, start, out_rdy=1 -> words {0x0005_0002_0000_0000/FF, 0xA/00, 0xB/80}, TXCNT=1, empty=1.
REQ-032 Same frame, out_rdy toggled 1,0,0,1,0,1 -> identical 3-word sequence, no duplicates, out_wr never high after an out_rdy=0 cycle.
REQ-033 LENGTH=3 with 2 pushed, start -> no out_wr, err=1; CLEAR write -> err=0.
REQ-034 Push 9 words into DEPTH=8 -> count=8, full=1, ovf=1, 9th word never transmitted.
REQ-035 LENGTH=0, start -> single header word ctrl 0xFF, then IDLE; rst asserted in VAL of 4-word frame -> out_wr=0 next cycle, STATUS=0x0800.
REQ-036 With TLV_ENC_CHECKSUM_EN, TYPE=1, LENGTH=1, value 0xF0 -> trailer 0x0001_0001_0000_00F0 with ctrl 0x80.
